ir_array_scan: RTL and testbench



---
 rtl/ir_array_scan.sv | 177 +++++++++++++++++
 tb/tb_ir_array_scan.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ir_array_scan.sv
// IR reflectance-array scanner: periodic emitter enable, settle, then NUM_CH A2D conversions.
// Define IR_SCAN_FILT_EN to store an IIR average (old + new + 1) >> 1 instead of raw samples.
module ir_array_scan #(
    parameter int unsigned        NUM_CH     = 8,
    parameter int unsigned        RES_W      = 12,
    parameter int unsigned        ROUND_W    = 18,
    parameter int unsigned        SETTLE_W   = 12,
    parameter logic [RES_W-1:0]   LINE_THRES = 12'h040
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cnv_cmplt,
    input  logic [RES_W-1:0]          res,
    output logic                      strt_cnv,
    output logic [2:0]                chnnl,
    output logic                      IR_en,
    output logic                      IR_vld,
    output logic [NUM_CH*RES_W-1:0]   ir_vals,
    output logic                      line_present,
    output logic [2:0]                max_ch,
    output logic [RES_W-1:0]          max_val,
    output logic                      overrun
);

    localparam int unsigned CH_W   = 3;
    localparam int unsigned VALS_W = NUM_CH * RES_W;

    typedef enum logic [2:0] {IDLE, SETTLE, CONV, START, DONE} state_t;

    state_t              state, state_d;
    logic [ROUND_W-1:0]  round_cnt;
    logic [SETTLE_W-1:0] settle_cnt, settle_cnt_d;
    logic [CH_W-1:0]     chnnl_d, max_ch_d, run_idx, run_idx_d;
    logic [RES_W-1:0]    max_val_d, run_max, run_max_d, cap_val;
    logic [VALS_W-1:0]   ir_vals_d;
    logic                strt_cnv_d, IR_en_d, IR_vld_d, line_present_d, overrun_d;
    logic                round_tick_c;

    assign round_tick_c = &round_cnt;

`ifdef IR_SCAN_FILT_EN
    logic             first_scan, first_scan_d;
    logic [RES_W-1:0] old_val;
    logic [RES_W:0]   sum;

    // Rounded-half-up average of the stored value and the new sample
    always_comb begin
        old_val = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (chnnl == CH_W'(k)) old_val = ir_vals[k*RES_W +: RES_W];
        end
        sum     = {1'b0, old_val} + {1'b0, res} + (RES_W+1)'(1);
        cap_val = first_scan ? res : sum[RES_W:1];
    end
`else
    assign cap_val = res;
`endif

    // Next-state and next-output logic
    always_comb begin
        state_d        = state;
        settle_cnt_d   = settle_cnt;
        chnnl_d        = chnnl;
        strt_cnv_d     = 1'b0;
        IR_en_d        = IR_en;
        IR_vld_d       = 1'b0;
        ir_vals_d      = ir_vals;
        line_present_d = line_present;
        max_ch_d       = max_ch;
        max_val_d      = max_val;
        overrun_d      = overrun;
        run_max_d      = run_max;
        run_idx_d      = run_idx;
`ifdef IR_SCAN_FILT_EN
        first_scan_d   = first_scan;
`endif

        if (round_tick_c && (state != IDLE)) overrun_d = 1'b1;

        case (state)
            IDLE: begin
                if (round_tick_c) begin
                    state_d      = SETTLE;
                    IR_en_d      = 1'b1;
                    settle_cnt_d = '0;
                    chnnl_d      = '0;
                end
            end
            SETTLE: begin
                settle_cnt_d = settle_cnt + SETTLE_W'(1);
                if (&settle_cnt) begin
                    strt_cnv_d = 1'b1;
                    state_d    = CONV;
                end
            end
            CONV: begin
                if (cnv_cmplt) begin
                    for (int k = 0; k < NUM_CH; k++) begin
                        if (chnnl == CH_W'(k)) ir_vals_d[k*RES_W +: RES_W] = cap_val;
                    end
                    // Strict compare: ties keep the lower channel index
                    if (cap_val > run_max) begin
                        run_max_d = cap_val;
                        run_idx_d = chnnl;
                    end
                    if (chnnl == CH_W'(NUM_CH-1)) begin
                        state_d = DONE;
                    end else begin
                        chnnl_d = chnnl + CH_W'(1);
                        state_d = START;
                    end
                end
            end
            START: begin
                strt_cnv_d = 1'b1;
                state_d    = CONV;
            end
            DONE: begin
                IR_vld_d       = 1'b1;
                IR_en_d        = 1'b0;
                max_ch_d       = run_idx;
                max_val_d      = run_max;
                line_present_d = (run_max > LINE_THRES);
                run_max_d      = '0;
                run_idx_d      = '0;
                chnnl_d        = '0;
                state_d        = IDLE;
`ifdef IR_SCAN_FILT_EN
                first_scan_d   = 1'b0;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            round_cnt    <= '0;
            settle_cnt   <= '0;
            chnnl        <= '0;
            strt_cnv     <= 1'b0;
            IR_en        <= 1'b0;
            IR_vld       <= 1'b0;
            ir_vals      <= '0;
            line_present <= 1'b0;
            max_ch       <= '0;
            max_val      <= '0;
            overrun      <= 1'b0;
            run_max      <= '0;
            run_idx      <= '0;
`ifdef IR_SCAN_FILT_EN
            first_scan   <= 1'b1;
`endif
        end else begin
            state        <= state_d;
            round_cnt    <= round_cnt + ROUND_W'(1);
            settle_cnt   <= settle_cnt_d;
            chnnl        <= chnnl_d;
            strt_cnv     <= strt_cnv_d;
            IR_en        <= IR_en_d;
            IR_vld       <= IR_vld_d;
            ir_vals      <= ir_vals_d;
            line_present <= line_present_d;
            max_ch       <= max_ch_d;
            max_val      <= max_val_d;
            overrun      <= overrun_d;
            run_max      <= run_max_d;
            run_idx      <= run_idx_d;
`ifdef IR_SCAN_FILT_EN
            first_scan   <= first_scan_d;
`endif
        end
    end

endmodule

// File: tb/tb_ir_array_scan.sv
// Directed bench for ir_array_scan with a behavioural A2D responder (4 channels, fast timers).
module tb_ir_array_scan;

    localparam int unsigned NCH = 4;
    localparam int unsigned RW  = 12;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cnv_cmplt = 1'b0;
    logic [RW-1:0]   res = '0;
    logic            strt_cnv;
    logic [2:0]      chnnl;
    logic            IR_en;
    logic            IR_vld;
    logic [NCH*RW-1:0] ir_vals;
    logic            line_present;
    logic [2:0]      max_ch;
    logic [RW-1:0]   max_val;
    logic            overrun;

    int            n_vec = 0;
    int            n_err = 0;
    int            lat = 10;
    logic [RW-1:0] tbl [8];

    logic          mon_clr = 1'b0;
    int            n_strt = 0;
    int            n_vld = 0;
    int            n_en = 0;
    logic [2:0]    seq [8];

    ir_array_scan #(
        .NUM_CH(NCH), .RES_W(RW), .ROUND_W(8), .SETTLE_W(4), .LINE_THRES(12'h040)
    ) dut (
        .clk(clk), .rst(rst), .cnv_cmplt(cnv_cmplt), .res(res),
        .strt_cnv(strt_cnv), .chnnl(chnnl), .IR_en(IR_en), .IR_vld(IR_vld),
        .ir_vals(ir_vals), .line_present(line_present), .max_ch(max_ch),
        .max_val(max_val), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // A2D responder: answers each start pulse after lat cycles with tbl[channel]
    initial begin : a2d
        logic [2:0] ch;
        forever begin
            @(negedge clk);
            if (strt_cnv) begin
                ch = chnnl;
                repeat (lat) @(negedge clk);
                res       = tbl[ch];
                cnv_cmplt = 1'b1;
                @(negedge clk);
                cnv_cmplt = 1'b0;
                res       = '0;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_clr) begin
            n_strt = 0;
            n_vld  = 0;
            n_en   = 0;
            for (int i = 0; i < 8; i++) seq[i] = '0;
        end else begin
            if (strt_cnv) begin
                if (n_strt < 8) seq[n_strt] = chnnl;
                n_strt++;
            end
            if (IR_vld) n_vld++;
            if (IR_en)  n_en++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_mon();
        @(posedge clk); #1 mon_clr = 1'b1;
        @(posedge clk); #1 mon_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_vld(input int bound);
        int i;
        i = 0;
        while (!IR_vld && i < bound) begin
            @(negedge clk);
            i++;
        end
        check("vld_seen", 64'(IR_vld), 64'd1);
    endtask

    task automatic set_tbl(input logic [RW-1:0] v0, input logic [RW-1:0] v1,
                           input logic [RW-1:0] v2, input logic [RW-1:0] v3);
        tbl[0] = v0; tbl[1] = v1; tbl[2] = v2; tbl[3] = v3;
        for (int i = 4; i < 8; i++) tbl[i] = '0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ir_en"},   64'(IR_en), 64'd0);
        check({tag, "_strt"},    64'(strt_cnv), 64'd0);
        check({tag, "_vld"},     64'(IR_vld), 64'd0);
        check({tag, "_ir_vals"}, 64'(ir_vals), 64'd0);
        check({tag, "_max_val"}, 64'(max_val), 64'd0);
        check({tag, "_max_ch"},  64'(max_ch), 64'd0);
        check({tag, "_line"},    64'(line_present), 64'd0);
        check({tag, "_chnnl"},   64'(chnnl), 64'd0);
        check({tag, "_overrun"}, 64'(overrun), 64'd0);
    endtask

    initial begin : main
        int i;
        set_tbl(12'h100, 12'h300, 12'h200, 12'h050);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_state("rst");
        rst = 1'b0;

`ifdef IR_SCAN_FILT_EN
        set_tbl(12'h100, 12'h100, 12'h100, 12'h100);
        wait_vld(1000);
        check("filt_scan1_ch0", 64'(ir_vals[11:0]), 64'h100);
        @(negedge clk);
        tbl[0] = 12'h201;
        wait_vld(1000);
        check("filt_scan2_ch0", 64'(ir_vals[11:0]), 64'h181);
        check("filt_scan2_ch1", 64'(ir_vals[23:12]), 64'h100);
`else
        // Basic scan: distinct values, channel 1 strongest
        clr_mon();
        wait_vld(1000);
        check("t1_ir_vals", 64'(ir_vals), 64'h050_200_300_100);
        check("t1_max_ch",  64'(max_ch), 64'd1);
        check("t1_max_val", 64'(max_val), 64'h300);
        check("t1_line",    64'(line_present), 64'd1);
        check("t1_ir_en_off", 64'(IR_en), 64'd0);
        repeat (3) @(negedge clk);
        check("t1_n_vld",  64'(n_vld), 64'd1);
        check("t1_n_strt", 64'(n_strt), 64'd4);
        check("t1_seq",    64'({seq[3], seq[2], seq[1], seq[0]}), 64'(12'b011_010_001_000));
        check("t1_en_cycles", 64'(n_en), 64'd64);
        check("t1_overrun", 64'(overrun), 64'd0);

        // All at threshold: strict compare, lowest index kept
        set_tbl(12'h040, 12'h040, 12'h040, 12'h040);
        clr_mon();
        wait_vld(1000);
        check("t2_ir_vals", 64'(ir_vals), 64'h040_040_040_040);
        check("t2_line",    64'(line_present), 64'd0);
        check("t2_max_ch",  64'(max_ch), 64'd0);
        check("t2_max_val", 64'(max_val), 64'h040);

        // Tie on channels 1 and 3
        set_tbl(12'h010, 12'h200, 12'h100, 12'h200);
        clr_mon();
        wait_vld(1000);
        check("t3_ir_vals", 64'(ir_vals), 64'h200_100_200_010);
        check("t3_max_ch",  64'(max_ch), 64'd1);
        check("t3_max_val", 64'(max_val), 64'h200);
        check("t3_line",    64'(line_present), 64'd1);

        // Reset during the channel-2 conversion
        set_tbl(12'h100, 12'h300, 12'h200, 12'h050);
        @(negedge clk);
        i = 0;
        while (!(strt_cnv && chnnl == 3'd2) && i < 1000) begin
            @(negedge clk);
            i++;
        end
        check("t5_reached_ch2", 64'(strt_cnv && chnnl == 3'd2), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("t5_mid");
        rst = 1'b0;
        clr_mon();
        wait_vld(1000);
        check("t5_n_strt", 64'(n_strt), 64'd4);
        check("t5_seq",    64'({seq[3], seq[2], seq[1], seq[0]}), 64'(12'b011_010_001_000));
        check("t5_ir_vals", 64'(ir_vals), 64'h050_200_300_100);
        check("t5_max_ch", 64'(max_ch), 64'd1);
        check("t5_overrun_clear", 64'(overrun), 64'd0);

        // Slow A2D: scan spans round ticks
        lat = 300;
        clr_mon();
        wait_vld(4000);
        check("t4_overrun", 64'(overrun), 64'd1);
        check("t4_n_strt",  64'(n_strt), 64'd4);
        check("t4_ir_vals", 64'(ir_vals), 64'h050_200_300_100);
        check("t4_max_val", 64'(max_val), 64'h300);
        lat = 10;
        @(negedge clk);
        check("t4_ir_en_idle", 64'(IR_en), 64'd0);
        clr_mon();
        wait_vld(1000);
        check("t4_overrun_sticky", 64'(overrun), 64'd1);
        check("t4_next_n_strt", 64'(n_strt), 64'd4);
        check("t4_next_max_ch", 64'(max_ch), 64'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
